// File: rtl/filter_uart_reporter_pkg.sv
// Shared constants, ASCII helper and frame FSM state type for filter_uart_reporter.
package filter_uart_reporter_pkg;

    localparam logic [7:0] AsciiCr = 8'h0D;
    localparam logic [7:0] AsciiLf = 8'h0A;
    localparam logic [7:0] AsciiSp = 8'h20;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWait
    } frame_state_e;

    // Uppercase hex digit for one nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/filter_uart_reporter_if.sv
// Sample handshake and status bundle between the filter stage and the UART reporter.
interface filter_uart_reporter_if;

    logic [7:0] sample_in;
    logic       sample_valid;
    logic       busy;
    logic       overrun;
    logic [7:0] drop_count;

    modport master (
        output sample_in,
        output sample_valid,
        input  busy,
        input  overrun,
        input  drop_count
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output busy,
        output overrun,
        output drop_count
    );

endinterface

// File: rtl/uart_tx_8n1.sv
// Bit-level 8N1 UART transmitter; TX is registered from next-state so it never glitches.
module uart_tx_8n1 #(
    parameter int unsigned BIT_CYCLES = 104
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_done,
    output logic       TX
);

    localparam int unsigned CntW = $clog2(BIT_CYCLES + 1);

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_e;

    tx_state_e       r_state, w_state_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]      r_bit_idx, w_bit_idx_nxt;
    logic [7:0]      r_data, w_data_nxt;
    logic            r_tx, w_tx_nxt;
    logic            w_bit_end;

    assign w_bit_end = (r_cnt == CntW'(BIT_CYCLES - 1));
    assign TX        = r_tx;

    // State, baud counter, shift data and line level registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= TxIdle;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_data    <= w_data_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    // Next-state, next line level and done pulse; counter reloads on every bit boundary.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_data_nxt    = r_data;
        w_tx_nxt      = r_tx;
        tx_done       = 1'b0;
        unique case (r_state)
            TxIdle: begin
                if (tx_start) begin
                    w_data_nxt  = tx_data;
                    w_cnt_nxt   = '0;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = TxStart;
                end
            end
            TxStart: begin
                if (w_bit_end) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = 3'd0;
                    w_tx_nxt      = r_data[0];
                    w_state_nxt   = TxData;
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            TxData: begin
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = TxStop;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = r_data[r_bit_idx + 3'd1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            TxStop: begin
                if (w_bit_end) begin
                    tx_done     = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = TxIdle;
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            default: w_state_nxt = TxIdle;
        endcase
    end

endmodule

// File: rtl/filter_uart_reporter.sv
// Formats each accepted filter sample as ASCII hex + CR LF and sends it over UART.
// Optional macro REPORT_SEQ_EN prefixes an 8-bit sequence number and a space.
module filter_uart_reporter
    import filter_uart_reporter_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 12_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned BIT_CYCLES = CLK_FREQ / BAUD
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    filter_uart_reporter_if.slave  rpt,
    output logic                   TX
);

`ifdef REPORT_SEQ_EN
    localparam logic [2:0] LastIdx = 3'd6;
`else
    localparam logic [2:0] LastIdx = 3'd3;
`endif

    frame_state_e r_state, w_state_nxt;
    logic [2:0]   r_idx, w_idx_nxt;
    logic         r_gap, w_gap_nxt;
    logic [7:0]   r_sample;
    logic         r_overrun;
    logic [7:0]   r_drop_count;
    logic         w_accept, w_drop, w_last, w_frame_end;
    logic         w_tx_start, w_tx_done;
    logic [7:0]   w_byte;
`ifdef REPORT_SEQ_EN
    logic [7:0]   r_seq;
`endif

    assign w_last      = (r_idx == LastIdx);
    assign w_drop      = rpt.sample_valid && (r_state != StIdle);
    assign w_frame_end = (r_state == StWait) && w_tx_done && w_last;

    assign rpt.busy       = (r_state != StIdle);
    assign rpt.overrun    = r_overrun;
    assign rpt.drop_count = r_drop_count;

    // Frame state, byte index and inter-byte gap flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_gap   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    // Frame sequencing; the gap flag adds the second idle cycle between bytes,
    // while the last byte returns to idle directly on tx_done.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_gap_nxt   = 1'b0;
        w_tx_start  = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (rpt.sample_valid) begin
                    w_accept    = 1'b1;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = StLoad;
                end
            end
            StLoad: begin
                w_tx_start  = 1'b1;
                w_state_nxt = StWait;
            end
            StWait: begin
                if (r_gap) begin
                    w_idx_nxt   = r_idx + 3'd1;
                    w_state_nxt = StLoad;
                end else if (w_tx_done) begin
                    if (w_last) w_state_nxt = StIdle;
                    else        w_gap_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Sample capture, overrun pulse and saturating drop counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sample     <= '0;
            r_overrun    <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_accept) r_sample <= rpt.sample_in;
            r_overrun <= w_drop;
            if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
        end
    end

`ifdef REPORT_SEQ_EN
    // Sequence number advances once a frame completes, so a frame carries its own value.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)           r_seq <= '0;
        else if (w_frame_end) r_seq <= r_seq + 8'd1;
    end

    // Byte selection for the 7-byte frame.
    always_comb begin
        w_byte = AsciiLf;
        unique case (r_idx)
            3'd0:    w_byte = hex_ascii(r_seq[7:4]);
            3'd1:    w_byte = hex_ascii(r_seq[3:0]);
            3'd2:    w_byte = AsciiSp;
            3'd3:    w_byte = hex_ascii(r_sample[7:4]);
            3'd4:    w_byte = hex_ascii(r_sample[3:0]);
            3'd5:    w_byte = AsciiCr;
            default: w_byte = AsciiLf;
        endcase
    end
`else
    // Byte selection for the 4-byte frame.
    always_comb begin
        w_byte = AsciiLf;
        unique case (r_idx)
            3'd0:    w_byte = hex_ascii(r_sample[7:4]);
            3'd1:    w_byte = hex_ascii(r_sample[3:0]);
            3'd2:    w_byte = AsciiCr;
            default: w_byte = AsciiLf;
        endcase
    end
`endif

    uart_tx_8n1 #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_uart_tx (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .tx_data (w_byte),
        .tx_start(w_tx_start),
        .tx_done (w_tx_done),
        .TX      (TX)
    );

endmodule
